// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: issues FIFO reads, absorbs the one-cycle read latency
// in a 2-entry skid buffer, and delivers a valid/ready stream with packet framing.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_rd,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t                           state, state_nxt;
    logic [1:0]                       occ;
    logic                             inflight;
    logic [BW-1:0]                    issue_cnt, beat_cnt;
    logic [1:0][DATA_WIDTH-1:0]       skid;
    logic                             fire, may_issue, drained;
    logic [1:0]                       pending;

    assign out_valid = (occ != 2'd0);
    assign out_data  = skid[0];
    assign fire      = out_valid && out_ready;
    assign out_last  = out_valid && (beat_cnt == LAST);
    assign busy      = (state != IDLE);

    // Entries that will be held after this cycle if no new read is issued.
    assign pending   = occ + {1'b0, inflight} - {1'b0, fire};
    assign may_issue = (state == RUN) || (state == FINISH && issue_cnt != '0);
    assign rd_en     = may_issue && !empty && (pending < 2'd2);
    assign drained   = (issue_cnt == '0) && (occ == 2'd0) && !inflight;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN:     if (!enable) state_nxt = drained ? IDLE : FINISH;
            FINISH: begin
                if (enable)       state_nxt = RUN;
                else if (drained) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            inflight  <= 1'b0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            word_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_en;
            if (rd_en)
                issue_cnt <= (issue_cnt == LAST) ? '0 : issue_cnt + 1'b1;
            if (fire) begin
                beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    // Skid buffer: head at index 0; a returning word lands at the tail,
    // which shifts down by one when the head is popped in the same cycle.
    always_ff @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= 2'd0;
            skid <= '0;
        end else if (inflight && fire) begin
            if (occ == 2'd2) begin
                skid[0] <= skid[1];
                skid[1] <= fifo_data;
            end else begin
                skid[0] <= fifo_data;
            end
        end else if (inflight) begin
            if (occ == 2'd0) skid[0] <= fifo_data;
            else             skid[1] <= fifo_data;
            occ <= occ + 2'd1;
        end else if (fire) begin
            skid[0] <= skid[1];
            occ     <= occ - 2'd1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO source, stream monitor with
// ordering/hold/outstanding checks, directed scenarios and a narrow-counter instance.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       empty;
    logic [7:0] fifo_data = 8'h00;
    logic       rd_en;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic [15:0] word_cnt;

    // narrow-counter instance with a never-empty counting source
    logic       rst4_n = 1'b0;
    logic       en4 = 1'b0;
    logic       rdy4 = 1'b0;
    logic [7:0] data4, src4;
    logic       rd4, v4, l4, b4;
    logic [7:0] d4;
    logic [3:0] wc4;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_WIDTH(8), .BURST_LEN(16), .CNT_WIDTH(16)) dut (
        .clk_rd(clk), .rst_n(rst_n), .enable(enable), .empty(empty),
        .fifo_data(fifo_data), .rd_en(rd_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .word_cnt(word_cnt)
    );

    fifo_rd_stream #(.DATA_WIDTH(8), .BURST_LEN(16), .CNT_WIDTH(4)) dut4 (
        .clk_rd(clk), .rst_n(rst4_n), .enable(en4), .empty(1'b0),
        .fifo_data(data4), .rd_en(rd4), .out_valid(v4),
        .out_ready(rdy4), .out_data(d4), .out_last(l4),
        .busy(b4), .word_cnt(wc4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO model: data appears one cycle after an accepted read
    logic [7:0] mem [0:1023];
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rd_en && !empty) begin
            fifo_data <= mem[rd_ptr[9:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(posedge clk or negedge rst4_n) begin
        if (!rst4_n) begin
            src4  <= 8'h00;
            data4 <= 8'h00;
        end else if (rd4) begin
            data4 <= src4;
            src4  <= src4 + 8'd1;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // monitor state
    logic [7:0] rx_q[$];
    logic       rxl_q[$];
    logic [7:0] rx4_q[$];
    logic       rx4l_q[$];
    int iss = 0, rx_total = 0, n_last = 0, rd_run = 0, rd_run_max = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            rx_q.delete(); rxl_q.delete();
            iss = 0; rx_total = 0; n_last = 0; rd_run = 0; rd_run_max = 0;
            prev_stall = 1'b0;
        end else begin
            n_tests++;
            assert (iss - rx_total <= 2) else begin
                n_fail++;
                $display("FAIL outstanding: got %0d, limit 2", iss - rx_total);
            end
            check("rd_en_while_empty", int'(rd_en && empty), 0);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                rx_q.push_back(out_data);
                rxl_q.push_back(out_last);
                rx_total++;
                if (out_last) n_last++;
            end
            if (rd_en) begin
                iss++;
                rd_run++;
                if (rd_run > rd_run_max) rd_run_max = rd_run;
            end else begin
                rd_run = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst4_n && v4 && rdy4) begin
            rx4_q.push_back(d4);
            rx4l_q.push_back(l4);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // reset, preload n words 0..n-1, release reset; leaves us at posedge+1
    task automatic start(input int n);
        rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0;
        tick(1);
        wr_ptr = rd_ptr;
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[9:0]] = 8'(i);
            wr_ptr++;
        end
        tick(1);
        rst_n = 1'b1;
    endtask

    task automatic load(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[9:0]] = 8'(base + i);
            wr_ptr++;
        end
    endtask

    task automatic check_seq(input string name, input int n);
        int errs;
        errs = 0;
        check({name, "_count"}, rx_q.size(), n);
        for (int i = 0; i < rx_q.size() && i < n; i++) begin
            if (rx_q[i] != 8'(i)) errs++;
            if (rxl_q[i] != ((i % 16) == 15)) errs++;
        end
        check({name, "_order_last_errs"}, errs, 0);
    endtask

    typedef struct {
        logic        enable;
        logic        ready;
        logic        rd_en;
        logic        valid;
        logic [7:0]  data;
        logic        last;
        logic        busy;
        logic [15:0] wcnt;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int t_iss, t_last, at_idle;

        // start-up of a full-throughput drain, cycle by cycle
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 16'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 16'd1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 16'd2};

        // reset state
        #2;
        check("rst_rd_en", rd_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_wcnt", word_cnt, 0);

        // 1: 32 words at full throughput
        start(32);
        for (int i = 0; i < 6; i++) begin
            enable    = tbl[i].enable;
            out_ready = tbl[i].ready;
            #3;
            check($sformatf("v%0d_rd_en", i), rd_en, tbl[i].rd_en);
            check($sformatf("v%0d_valid", i), out_valid, tbl[i].valid);
            check($sformatf("v%0d_data", i), out_data, tbl[i].data);
            check($sformatf("v%0d_last", i), out_last, tbl[i].last);
            check($sformatf("v%0d_busy", i), busy, tbl[i].busy);
            check($sformatf("v%0d_wcnt", i), word_cnt, tbl[i].wcnt);
            tick(1);
        end
        tick(34);
        check_seq("t1", 32);
        check("t1_rd_run", rd_run_max, 32);
        check("t1_reads", iss, 32);
        check("t1_lasts", n_last, 2);
        check("t1_wcnt", word_cnt, 32);
        check("t1_busy_on", busy, 1);
        enable = 1'b0;
        tick(2);
        check("t1_busy_off", busy, 0);

        // 2: out_ready toggling every cycle
        start(32);
        enable = 1'b1;
        for (int c = 0; c < 200 && rx_q.size() < 32; c++) begin
            out_ready = ~out_ready;
            tick(1);
        end
        out_ready = 1'b1;
        tick(4);
        check_seq("t2", 32);
        check("t2_lasts", n_last, 2);

        // 3: enable dropped after 5 accepted beats, 20 words available
        start(20);
        enable = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 50 && rx_q.size() < 5; c++) tick(1);
        enable = 1'b0;
        at_idle = -1;
        for (int c = 0; c < 100 && at_idle < 0; c++) begin
            tick(1);
            if (!busy) at_idle = rx_q.size();
        end
        check("t3_beats_at_idle", at_idle, 16);
        tick(10);
        check_seq("t3", 16);
        check("t3_fifo_left", wr_ptr - rd_ptr, 4);
        check("t3_reads", iss, 16);
        check("t3_busy", busy, 0);

        // 4: FIFO runs dry after 7 words, refilled 20 cycles later
        start(7);
        enable = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 40 && !empty; c++) tick(1);
        t_iss = iss; t_last = n_last;
        tick(20);
        check("t4_gap_reads", iss, t_iss);
        check("t4_gap_lasts", n_last, t_last);
        check("t4_gap_beats", rx_q.size(), 7);
        check("t4_gap_busy", busy, 1);
        load(7, 9);
        for (int c = 0; c < 40 && rx_q.size() < 16; c++) tick(1);
        tick(3);
        check_seq("t4", 16);
        check("t4_lasts", n_last, 1);

        // 5: reset while reads are in flight
        start(32);
        enable = 1'b1; out_ready = 1'b1;
        tick(8);
        check("t5_pre_busy", busy, 1);
        check("t5_pre_outstanding", iss - rx_total, 2);
        rst_n = 1'b0; enable = 1'b0;
        #2;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_rd_en", rd_en, 0);
        check("t5_rst_wcnt", word_cnt, 0);
        tick(1);
        rst_n = 1'b1;
        tick(10);
        check("t5_post_beats", rx_q.size(), 0);
        check("t5_post_reads", iss, 0);
        check("t5_post_valid", out_valid, 0);
        check("t5_post_busy", busy, 0);

        // 6: 4-bit word counter wraps after 16, framing unaffected
        rst4_n = 1'b1; en4 = 1'b1; rdy4 = 1'b1;
        for (int c = 0; c < 60 && rx4_q.size() < 20; c++) tick(1);
        rdy4 = 1'b0;
        tick(2);
        check("t6_beats", rx4_q.size(), 20);
        check("t6_wcnt", wc4, 4);
        begin
            int errs;
            errs = 0;
            for (int i = 0; i < rx4_q.size(); i++) begin
                if (rx4_q[i] != 8'(i)) errs++;
                if (rx4l_q[i] != (i == 15)) errs++;
            end
            check("t6_order_last_errs", errs, 0);
        end
        check("t6_hold_valid", v4, 1);
        check("t6_hold_data", d4, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
